// File: rtl/ring_phase_decoder_if.sv
// Phase/status bundle between a ring-counter source and the decoder.
// master: drives phase_in/ack_err; slave: drives the decoded status.
interface ring_phase_decoder_if #(
    parameter int REV_W = 8
);
    logic [7:0]       phase_in;
    logic             ack_err;
    logic [2:0]       phase_idx;
    logic             phase_valid;
    logic             rev_pulse;
    logic [REV_W-1:0] rev_count;
    logic             seq_err;
    logic [1:0]       sync_state;

    modport master (
        output phase_in,
        output ack_err,
        input  phase_idx,
        input  phase_valid,
        input  rev_pulse,
        input  rev_count,
        input  seq_err,
        input  sync_state
    );

    modport slave (
        input  phase_in,
        input  ack_err,
        output phase_idx,
        output phase_valid,
        output rev_pulse,
        output rev_count,
        output seq_err,
        output sync_state
    );
endinterface

// File: rtl/ring_phase_decoder.sv
// Decodes a one-hot 8-stage ring phase, tracks sequence, counts revolutions.
// Ports: clk, clear_n (async low), bus (slave: phase_in/ack_err -> status).
module ring_phase_decoder #(
    parameter int REV_W = 8
) (
    input  logic                  clk,
    input  logic                  clear_n,
    ring_phase_decoder_if.slave   bus
);
    typedef enum logic [1:0] {
        SYNC  = 2'b00,
        TRACK = 2'b01,
        ERROR = 2'b10
    } state_t;

    state_t           state;
    logic [7:0]       phase_r;
    logic [7:0]       prev_r;
    logic [2:0]       idx_q;
    logic             valid_q;
    logic             pulse_q;
    logic [REV_W-1:0] count_q;
    logic             err_q;

    logic [2:0] cur_idx;
    logic       legal;
    logic       succ;
    logic       wrap;
    logic       is_first;

    // OR-reduce of set-bit positions; only trusted when legal.
    always_comb begin
        cur_idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (phase_r[i]) cur_idx = cur_idx | 3'(i);
        end
    end

    assign legal    = (phase_r != 8'h00) &&
                      ((phase_r & (phase_r - 8'h01)) == 8'h00);
    assign succ     = legal &&
                      (phase_r == {prev_r[6:0], prev_r[7]});
    assign is_first = (phase_r == 8'h01);
    assign wrap     = is_first && (prev_r == 8'h80);

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state   <= SYNC;
            phase_r <= '0;
            prev_r  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            pulse_q <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            phase_r <= bus.phase_in;
            prev_r  <= phase_r;
            pulse_q <= 1'b0;
            unique case (state)
                SYNC: begin
                    valid_q <= 1'b0;
                    if (is_first) begin
                        state   <= TRACK;
                        valid_q <= 1'b1;
                        idx_q   <= 3'd0;
                    end
                end
                TRACK: begin
                    if (succ) begin
                        valid_q <= 1'b1;
                        idx_q   <= cur_idx;
                        if (wrap) begin
                            pulse_q <= 1'b1;
                            count_q <= count_q + 1'b1;
                        end
                    end else if (is_first) begin
                        // Upstream ring was cleared: restart silently.
                        valid_q <= 1'b1;
                        idx_q   <= 3'd0;
                    end else begin
                        state   <= ERROR;
                        err_q   <= 1'b1;
                        valid_q <= 1'b0;
                    end
                end
                ERROR: begin
                    valid_q <= 1'b0;
                    // Always via SYNC, even if phase_r is already 0x01.
                    if (bus.ack_err) begin
                        state <= SYNC;
                        err_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= SYNC;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.phase_idx   = idx_q;
    assign bus.phase_valid = valid_q;
    assign bus.rev_pulse   = pulse_q;
    assign bus.rev_count   = count_q;
    assign bus.seq_err     = err_q;
    assign bus.sync_state  = state;
endmodule

// File: tb/tb_ring_phase_decoder.sv
// Randomized + directed bench for ring_phase_decoder, REV_W=8 and REV_W=2,
// against an index-arithmetic reference model.
module tb_ring_phase_decoder;
    logic       clk = 1'b0;
    logic       clear_n = 1'b0;
    logic [7:0] phase_in = 8'h00;
    logic       ack_err = 1'b0;

    int total = 0;
    int bad = 0;

    ring_phase_decoder_if #(.REV_W(8)) b8 ();
    ring_phase_decoder_if #(.REV_W(2)) b2 ();

    assign b8.phase_in = phase_in;
    assign b8.ack_err  = ack_err;
    assign b2.phase_in = phase_in;
    assign b2.ack_err  = ack_err;

    ring_phase_decoder #(.REV_W(8)) dut8 (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (b8)
    );

    ring_phase_decoder #(.REV_W(2)) dut2 (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (b2)
    );

    always #5 clk = ~clk;

    // Reference model: phases tracked as ring positions.
    logic [7:0] m_ph, m_prev;
    int m_st, m_idx, m_cnt;
    bit m_valid, m_pulse, m_err;

    function automatic bit one_hot(input logic [7:0] v);
        return $countones(v) == 1;
    endfunction

    function automatic int pos(input logic [7:0] v);
        for (int i = 0; i < 8; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    task automatic m_reset();
        m_ph = 0; m_prev = 0; m_st = 0; m_idx = 0;
        m_cnt = 0; m_valid = 0; m_pulse = 0; m_err = 0;
    endtask

    task automatic m_edge(input logic [7:0] p, input bit a);
        bit in_seq;
        in_seq = one_hot(m_ph) && one_hot(m_prev) &&
                 pos(m_ph) == (pos(m_prev) + 1) % 8;
        m_pulse = 0;
        if (m_st == 0) begin
            m_valid = 0;
            if (m_ph == 8'h01) begin
                m_st = 1; m_valid = 1; m_idx = 0;
            end
        end else if (m_st == 1) begin
            if (in_seq) begin
                m_valid = 1;
                m_idx = pos(m_ph);
                if (pos(m_prev) == 7) begin
                    m_pulse = 1;
                    m_cnt++;
                end
            end else if (m_ph == 8'h01) begin
                m_valid = 1; m_idx = 0;
            end else begin
                m_st = 2; m_err = 1; m_valid = 0;
            end
        end else begin
            m_valid = 0;
            if (a) begin
                m_st = 0; m_err = 0;
            end
        end
        m_prev = m_ph;
        m_ph = p;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all();
        chk("state8", 32'(b8.sync_state), 32'(m_st));
        chk("valid8", 32'(b8.phase_valid), 32'(m_valid));
        chk("idx8", 32'(b8.phase_idx), 32'(m_idx));
        chk("pulse8", 32'(b8.rev_pulse), 32'(m_pulse));
        chk("cnt8", 32'(b8.rev_count), 32'(m_cnt % 256));
        chk("err8", 32'(b8.seq_err), 32'(m_err));
        chk("state2", 32'(b2.sync_state), 32'(m_st));
        chk("pulse2", 32'(b2.rev_pulse), 32'(m_pulse));
        chk("cnt2", 32'(b2.rev_count), 32'(m_cnt % 4));
    endtask

    task automatic cyc(input logic [7:0] p, input bit a);
        phase_in = p;
        ack_err = a;
        @(posedge clk);
        m_edge(p, a);
        @(negedge clk);
        chk_all();
    endtask

    task automatic revs(input int n);
        for (int r = 0; r < n; r++)
            for (int i = 0; i < 8; i++)
                cyc(8'(1 << i), 1'b0);
    endtask

    initial begin
        int cur;
        int r;
        logic [7:0] p;
        logic [7:0] last;
        m_reset();
        repeat (3) @(negedge clk);
        chk_all();
        clear_n = 1'b1;
        @(negedge clk);

        cyc(8'h00, 0);
        cyc(8'h40, 0);
        revs(3);
        cyc(8'h01, 0);
        cyc(8'h02, 0);

        cyc(8'h04, 0);
        cyc(8'h10, 0);
        repeat (4) cyc(8'h01, 0);
        cyc(8'h01, 1);
        repeat (3) cyc(8'h01, 0);

        cyc(8'h02, 0);
        cyc(8'h04, 0);
        cyc(8'h08, 0);
        cyc(8'h01, 0);
        cyc(8'h02, 0);
        cyc(8'h04, 0);
        cyc(8'h08, 0);

        cyc(8'h22, 0);
        cyc(8'h01, 0);
        cyc(8'h01, 0);
        cyc(8'h01, 1);
        repeat (3) cyc(8'h01, 0);

        cur = 0;
        last = 8'h01;
        for (int k = 0; k < 600; k++) begin
            r = $urandom_range(0, 99);
            if (r < 75) begin
                cur = (cur + 1) % 8;
                p = 8'(1 << cur);
            end else if (r < 82) begin
                cur = 0;
                p = 8'h01;
            end else if (r < 88) begin
                p = last;
            end else if (r < 94) begin
                cur = (cur + 2) % 8;
                p = 8'(1 << cur);
            end else begin
                p = 8'($urandom);
            end
            last = p;
            cyc(p, $urandom_range(0, 3) == 0);
        end

        cyc(8'h01, 1);
        cyc(8'h01, 0);
        cyc(8'h01, 0);
        cyc(8'h02, 0);
        cyc(8'h04, 0);
        #2;
        clear_n = 1'b0;
        #1;
        m_reset();
        chk_all();
        chk("async_ph", 32'(dut8.phase_r), 32'h0);
        @(negedge clk);
        chk_all();
        clear_n = 1'b1;

        cyc(8'h80, 0);
        cyc(8'h02, 0);
        revs(5);
        cyc(8'h01, 0);
        cyc(8'h02, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
